// File: rtl/interp_hold_filter.sv
// =============================================================================
// Module      : interp_hold_filter
// Description : Linear-interpolating upsampler (R = 2^LOG2_R) ahead of the
//               sigma-delta modulator. Optional macro INTERP_UNDERRUN_CNT_EN
//               adds a saturating underrun event counter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module interp_hold_filter #(
    parameter int LOG2_R = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_strobe,
    output logic        underrun,
    input  logic        clear_underrun
`ifdef INTERP_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int                ACC_W   = 17 + LOG2_R;
    localparam logic [LOG2_R-1:0] c_K_MAX = {LOG2_R{1'b1}};
    localparam logic [LOG2_R-1:0] c_K_ONE = LOG2_R'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_a, w_a_nxt;
    logic [15:0]         r_b, w_b_nxt;
    logic [15:0]         r_nxt, w_nxt_nxt;
    logic                r_nxt_valid, w_nxt_valid_nxt;
    logic [LOG2_R-1:0]   r_k, w_k_nxt;
    logic [ACC_W-1:0]    r_acc, w_acc_nxt;
    logic                r_underrun, w_underrun_nxt;

    logic                w_accept;
    logic                w_boundary;
    logic                w_underrun_evt;
    logic [16:0]         w_diff;
    logic [ACC_W-1:0]    w_slope;
    logic [ACC_W-1:0]    w_b_scaled;

    assign w_accept       = in_valid && !r_nxt_valid;
    assign w_boundary     = (r_state == S_RUN) ? (r_k == c_K_MAX) : r_nxt_valid;
    assign w_underrun_evt = w_boundary && !r_nxt_valid;
    assign w_diff         = {r_b[15], r_b} - {r_a[15], r_a};
    assign w_slope        = {{LOG2_R{w_diff[16]}}, w_diff};
    assign w_b_scaled     = {r_b[15], r_b, {LOG2_R{1'b0}}};

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_nxt_nxt       = r_nxt;
        w_nxt_valid_nxt = r_nxt_valid;
        w_k_nxt         = r_k;
        w_acc_nxt       = r_acc;
        w_underrun_nxt  = r_underrun;

        if (w_boundary) begin
            // New segment starts exactly on the previous endpoint.
            w_state_nxt = S_RUN;
            w_a_nxt     = r_b;
            w_k_nxt     = '0;
            w_acc_nxt   = w_b_scaled;
            if (r_nxt_valid) begin
                w_b_nxt         = r_nxt;
                w_nxt_valid_nxt = 1'b0;
            end
        end else if (r_state == S_RUN) begin
            w_k_nxt   = r_k + c_K_ONE;
            w_acc_nxt = r_acc + w_slope;
        end

        if (w_accept) begin
            w_nxt_nxt       = in_data;
            w_nxt_valid_nxt = 1'b1;
        end

        if (w_underrun_evt) begin
            w_underrun_nxt = 1'b1;
        end else if (clear_underrun) begin
            w_underrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_nxt       <= '0;
            r_nxt_valid <= 1'b0;
            r_k         <= '0;
            r_acc       <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_nxt       <= w_nxt_nxt;
            r_nxt_valid <= w_nxt_valid_nxt;
            r_k         <= w_k_nxt;
            r_acc       <= w_acc_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // Arithmetic shift by LOG2_R then truncation to 16 bits is this slice.
    assign out_data   = r_acc[LOG2_R +: 16];
    assign out_strobe = (r_state == S_RUN) && (r_k == '0);
    assign in_ready   = !r_nxt_valid;
    assign underrun   = r_underrun;

`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun_evt) begin
            if (clear_underrun) begin
                r_underrun_cnt <= 16'd1;
            end else if (r_underrun_cnt != 16'hFFFF) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end else if (clear_underrun) begin
            r_underrun_cnt <= '0;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interp_hold_filter.sv
// =============================================================================
// Module      : tb_interp_hold_filter
// Description : Bench for interp_hold_filter (LOG2_R = 2) against a
//               segment/phase reference model using closed-form interpolation.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_interp_hold_filter;

    localparam int LOG2_R = 2;
    localparam int R      = 1 << LOG2_R;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_strobe;
    logic        underrun;
    logic        clear_underrun;
`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    interp_hold_filter #(.LOG2_R(LOG2_R)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_strobe     (out_strobe),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
`ifdef INTERP_UNDERRUN_CNT_EN
        ,
        .underrun_cnt   (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: segment endpoints, phase, pending sample queue.
    bit m_run;
    int m_k, m_a, m_b;
    int m_pend[$];
    bit m_und;
    int m_cnt;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_out();
        if (!m_run) return 0;
        return m_a + fdiv(m_k * (m_b - m_a), R);
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_a = 0; m_b = 0;
        m_pend.delete();
        m_und = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input int d, input bit c);
        bit bnd, evt, acc;
        if (r) begin
            model_reset();
            return;
        end
        acc = v && (m_pend.size() == 0);
        bnd = m_run ? (m_k == R - 1) : (m_pend.size() != 0);
        evt = bnd && (m_pend.size() == 0);
        if (bnd) begin
            m_run = 1;
            m_k   = 0;
            m_a   = m_b;
            if (m_pend.size() != 0) m_b = m_pend.pop_front();
        end else if (m_run) begin
            m_k = m_k + 1;
        end
        if (evt) begin
            m_und = 1;
            m_cnt = c ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
        end else if (c) begin
            m_und = 0;
            m_cnt = 0;
        end
        if (acc) m_pend.push_back(d);
    endtask

    // One clock: compare outputs away from the edge, then drive and advance the model.
    task automatic cycle(input bit r, input bit v, input int d, input bit c);
        @(negedge clk);
        check("out_data",   int'($signed(out_data)), model_out());
        check("out_strobe", int'(out_strobe), int'(m_run && m_k == 0));
        check("in_ready",   int'(in_ready),   int'(m_pend.size() == 0));
        check("underrun",   int'(underrun),   int'(m_und));
`ifdef INTERP_UNDERRUN_CNT_EN
        check("underrun_cnt", int'(underrun_cnt), m_cnt);
`endif
        rst            = r;
        in_valid       = v;
        in_data        = d[15:0];
        clear_underrun = c;
        model_step(r, v, d, c);
    endtask

    task automatic feed(input int d);
        for (int i = 0; i < 4 * R; i++) begin
            if (m_pend.size() == 0) begin
                cycle(0, 1, d, 0);
                return;
            end
            cycle(0, 0, 0, 0);
        end
        check("feed_timeout", 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 16'd1234; clear_underrun = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset with in_valid high: nothing may be captured.
        for (int i = 0; i < 3; i++) cycle(1, 1, 1234, 0);
        cycle(0, 0, 0, 0);
        idle(3);
        check("no_capture_in_reset", int'(out_strobe), 0);

        // 0 -> 400 -> 800 then starve.
        feed(400);
        feed(800);
        idle(16);
        check("hold_800", int'($signed(out_data)), 800);
        check("underrun_set", int'(underrun), 1);

        // Negative floor rounding: 0 -> -1.
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0);
        feed(-1);
        idle(8);

        // Full-scale swing 32767 -> -32768.
        cycle(1, 0, 0, 0);
        feed(32767);
        feed(-32768);
        idle(12);
        check("hold_min", int'($signed(out_data)), -32768);

        // Mid-run reset at k = 2 with a pending sample.
        cycle(1, 0, 0, 0);
        feed(1000);
        feed(2000);
        feed(3000);
        for (int i = 0; i < 4 * R && !(m_run && m_k == 2 && m_pend.size() != 0); i++)
            cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        idle(2 * R);
        check("pending_dropped", int'($signed(out_data)), 0);

        // Starve three boundaries, then clear on a fourth underrun boundary.
        feed(500);
        for (int i = 0; i < 8 * R && m_cnt < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 2 * R && m_k != R - 1; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("clear_vs_set", int'(underrun), 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, v, c;
            int d;
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 3))
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($signed(16'($urandom())));
            endcase
            cycle(r, v, d, c);
        end
        cycle(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
